mul_pipe_unit: RTL and testbench
================================

Name: mul_pipe_unit

Overview:
Parametrised, pipelined successor to the execute-stage multiplier channel (M). It accepts one tagged multiply per cycle over a valid/ready handshake and carries operand tags alongside data through STAGES register stages. It returns {result, R1 tag, R0 tag} in the execute result format. Upper/lower product-half select, flush and per-stage bubble collapse are new relative to the single-cycle M path.

Parameters:
DATA_W, 16, operand/result data width
TAG_W, 5, rename tag width per operand
IMM_W, 5, immediate width (zero-extended to DATA_W)
STAGES, 3, pipeline register stages (legal range 1..8)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  request valid
in_ready  output  1  unit accepts request this cycle
in_r0  input  DATA_W+TAG_W  {data, tag} operand 0; tag in [TAG_W-1:0]
in_r1  input  DATA_W+TAG_W  {data, tag} operand 1
in_imm  input  IMM_W  immediate operand
in_imm_sel  input  1  1 = use in_imm in place of in_r1 data
in_high  input  1  1 = return upper DATA_W bits of product
in_signed  input  1  signed multiply request (see Optional Feature)
flush  input  1  synchronous kill of all in-flight operations
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_res  output  DATA_W+2*TAG_W  {result, r1_tag, r0_tag}
busy  output  1  any stage holds a valid op

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits 0; out_valid 0; out_res 0; busy 0. in_ready is 0 while rst_n is low and 1 on the first cycle after release.
- Accept: a transfer occurs on a clk edge when in_valid && in_ready.
- Operand B is {{DATA_W-IMM_W{1'b0}}, in_imm} when in_imm_sel, else in_r1 data.
- Captured r1_tag is in_r1 tag & ~{TAG_W{in_imm_sel}}. Captured r0_tag is the in_r0 tag.
- Product is the full 2*DATA_W result. in_high=0 selects [DATA_W-1:0] (low half wraps mod 2^DATA_W, no saturation). in_high=1 selects [2*DATA_W-1:DATA_W].
- Stage i holds {valid, partial/full product, in_high, in_signed, tags}. The partitioning of multiply work across stages is free, provided the final stage presents the full product.
- Latency: a request accepted at edge E gives out_valid=1 in the cycle after edge E+STAGES-1, i.e. STAGES cycles when there is no backpressure.
- Throughput: 1 op/cycle while out_ready=1.
- Bubble collapse: stage i advances when stage i+1 is empty or stage i+1 advances. The last stage advances when !out_valid or out_ready.
- in_ready = (stage0 empty or stage0 advances) && !flush.
- Backpressure: while out_valid && !out_ready, out_res and out_valid hold stable. Upstream stages keep filling holes until the pipe is full (STAGES ops held).
- Output is registered from the last stage. out_valid equals the last-stage valid bit. When out_valid=0, out_res holds its last value.
- Flush: at the edge where flush=1, all valid bits clear and in_valid is ignored. out_valid is 0 the following cycle. A simultaneous out_ready handshake in the flush cycle still counts as consumed.
- busy = OR of all stage valid bits.
- Reset asserted mid-operation: all in-flight ops are discarded immediately. No partial results emerge after release.

Optional Feature:
Macro SIGNED_MUL_EN.
- Defined: in_signed=1 treats the selected operands as two's complement, giving a signed 2*DATA_W product. The immediate is still zero-extended.
- Undefined: in_signed is ignored and all multiplies are unsigned; the port remains present and unconnected internally.
- The low half is identical in both modes; only in_high results differ.

Test Plan:
- Basic: r0=0x00EA/tag 0, r1=0x000B/tag 1, imm_sel=0, high=0, out_ready=1 -> after 3 cycles out_res={0x0A0E, 5'd1, 5'd0}.
- Immediate: r0=0x00EA/tag 0, r1 tag 1, imm=0x1F, imm_sel=1 -> out_res={0x1C56, 5'd0, 5'd0}.
- High half: r0=0x1234, r1=0x5678 -> high=0 gives 0x0060, high=1 gives 0x0626. Issue back-to-back; they must appear on consecutive cycles.
- Backpressure/collapse: stream 5 ops with out_ready=0 -> in_ready drops after 3 accepted and out_res is stable. Raise out_ready -> all 5 results emerge in order with no loss or duplication.
- Flush: issue 2 ops, assert flush one cycle later -> no out_valid for either op; busy=0 the cycle after flush; a new op accepted afterwards returns after 3 cycles.
- Signed (with SIGNED_MUL_EN): r0=0xFFFF, r1=0x0002, high=1 -> signed gives 0xFFFF, unsigned gives 0x0001. Without the macro, both give 0x0001.

Source files
------------

// File: rtl/mul_pipe_unit.sv
// Pipelined tagged multiplier: STAGES register stages with bubble collapse, flush and high/low half select.
// Optional SIGNED_MUL_EN: honour in_signed as a two's-complement request (immediate stays zero-extended).
module mul_pipe_unit #(
  parameter int DATA_W = 16,
  parameter int TAG_W  = 5,
  parameter int IMM_W  = 5,
  parameter int STAGES = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W+TAG_W-1:0]   in_r0,
  input  logic [DATA_W+TAG_W-1:0]   in_r1,
  input  logic [IMM_W-1:0]          in_imm,
  input  logic                      in_imm_sel,
  input  logic                      in_high,
  input  logic                      in_signed,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W+2*TAG_W-1:0] out_res,
  output logic                      busy
);

  localparam int PW = 2 * DATA_W;

  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [TAG_W-1:0]  tag0;
  logic [TAG_W-1:0]  tag1;
  logic              ext_a;
  logic              ext_b;
  logic [PW-1:0]     prod;
  logic              accept;

  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] high_q;
  logic [PW-1:0]     prod_q [STAGES];
  logic [TAG_W-1:0]  t0_q   [STAGES];
  logic [TAG_W-1:0]  t1_q   [STAGES];

  assign op_a = in_r0[TAG_W +: DATA_W];
  assign op_b = in_imm_sel ? {{(DATA_W-IMM_W){1'b0}}, in_imm} : in_r1[TAG_W +: DATA_W];
  assign tag0 = in_r0[TAG_W-1:0];
  assign tag1 = in_r1[TAG_W-1:0] & ~{TAG_W{in_imm_sel}};

`ifdef SIGNED_MUL_EN
  assign ext_a = in_signed & op_a[DATA_W-1];
  assign ext_b = in_signed & op_b[DATA_W-1];
`else
  logic unused_signed;
  assign unused_signed = in_signed;
  assign ext_a = 1'b0;
  assign ext_b = 1'b0;
`endif

  // Sign-extending to 2*DATA_W and truncating gives the signed product without a signed type.
  assign prod = {{DATA_W{ext_a}}, op_a} * {{DATA_W{ext_b}}, op_b};

  // Stage i moves on when some later stage has a hole or the consumer takes the output.
  for (genvar i = 0; i < STAGES; i++) begin : g_adv
    localparam int LO = (i + 1 < STAGES) ? i + 1 : STAGES - 1;
    assign adv[i] = out_ready || !(&vld[STAGES-1:LO]);
  end

  assign in_ready = rst_n && adv[0] && !flush;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld    <= '0;
      high_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        prod_q[i] <= '0;
        t0_q[i]   <= '0;
        t1_q[i]   <= '0;
      end
    end else begin
      if (flush) begin
        vld[0] <= 1'b0;
      end else if (adv[0]) begin
        vld[0] <= accept;
      end
      if (accept) begin
        prod_q[0] <= prod;
        high_q[0] <= in_high;
        t0_q[0]   <= tag0;
        t1_q[0]   <= tag1;
      end
      for (int i = 1; i < STAGES; i++) begin
        if (flush) begin
          vld[i] <= 1'b0;
        end else if (adv[i-1]) begin
          vld[i] <= vld[i-1];
        end else if (adv[i]) begin
          vld[i] <= 1'b0;
        end
        // Payload only moves with a valid op so an emptied output keeps its last value.
        if (adv[i-1] && vld[i-1]) begin
          prod_q[i] <= prod_q[i-1];
          high_q[i] <= high_q[i-1];
          t0_q[i]   <= t0_q[i-1];
          t1_q[i]   <= t1_q[i-1];
        end
      end
    end
  end

  assign out_valid = vld[STAGES-1];
  assign out_res   = {high_q[STAGES-1] ? prod_q[STAGES-1][PW-1:DATA_W] : prod_q[STAGES-1][DATA_W-1:0],
                      t1_q[STAGES-1], t0_q[STAGES-1]};
  assign busy      = |vld;

endmodule

// File: tb/tb_mul_pipe_unit.sv
// Bench for mul_pipe_unit at default parameters: vector table, corner sequences, randomized scoreboard.
module tb_mul_pipe_unit;

  localparam int STAGES = 3;
`ifdef SIGNED_MUL_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [20:0] in_r0;
  logic [20:0] in_r1;
  logic [4:0]  in_imm;
  logic        in_imm_sel;
  logic        in_high;
  logic        in_signed;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [25:0] out_res;
  logic        busy;

  mul_pipe_unit #(.DATA_W(16), .TAG_W(5), .IMM_W(5), .STAGES(STAGES)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_r0(in_r0), .in_r1(in_r1), .in_imm(in_imm), .in_imm_sel(in_imm_sel),
    .in_high(in_high), .in_signed(in_signed), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] r0;
    logic [4:0]  t0;
    logic [15:0] r1;
    logic [4:0]  t1;
    logic [4:0]  imm;
    bit          isel;
    bit          high;
    bit          sgn;
    logic [25:0] exp;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t tbl[10];
  logic [25:0] q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Reference: plain integer product of the selected operands.
  function automatic logic [25:0] model(input logic [15:0] a, input logic [4:0] t0,
                                        input logic [15:0] r1, input logic [4:0] t1,
                                        input logic [4:0] imm, input bit isel,
                                        input bit high, input bit sgn);
    longint av, bv, p;
    logic [15:0] b;
    logic [63:0] pb;
    b  = isel ? {11'b0, imm} : r1;
    av = longint'(a);
    bv = longint'(b);
    if (SGN && sgn) begin
      if (a >= 16'h8000) av = av - 65536;
      if (b >= 16'h8000) bv = bv - 65536;
    end
    p  = av * bv;
    pb = p;
    return {high ? pb[31:16] : pb[15:0], isel ? 5'd0 : t1, t0};
  endfunction

  task automatic drive(input vec_t v);
    in_r0      = {v.r0, v.t0};
    in_r1      = {v.r1, v.t1};
    in_imm     = v.imm;
    in_imm_sel = v.isel;
    in_high    = v.high;
    in_signed  = v.sgn;
  endtask

  task automatic issue_and_check(input string name, input vec_t v);
    int lat;
    @(negedge clk);
    drive(v);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    check({name, "_ready"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({name, "_latency"}, lat, STAGES);
    check({name, "_res"}, out_res, v.exp);
  endtask

  initial begin
    vec_t bp[5];
    vec_t rv;
    logic [25:0] held;
    bit have, seen, stall_prev;
    logic [25:0] prev_res;
    int sent, got;

    tbl[0] = '{16'h00EA, 5'd0,  16'h000B, 5'd1,  5'h00, 1'b0, 1'b0, 1'b0, {16'h0A0E, 5'd1, 5'd0}};
    tbl[1] = '{16'h00EA, 5'd0,  16'h0055, 5'd1,  5'h1F, 1'b1, 1'b0, 1'b0, {16'h1C56, 5'd0, 5'd0}};
    tbl[2] = '{16'h1234, 5'd4,  16'h5678, 5'd2,  5'h00, 1'b0, 1'b0, 1'b0, {16'h0060, 5'd2, 5'd4}};
    tbl[3] = '{16'h1234, 5'd4,  16'h5678, 5'd2,  5'h00, 1'b0, 1'b1, 1'b0, {16'h0626, 5'd2, 5'd4}};
    tbl[4] = '{16'hFFFF, 5'd3,  16'h0002, 5'd7,  5'h00, 1'b0, 1'b1, 1'b1, {SGN ? 16'hFFFF : 16'h0001, 5'd7, 5'd3}};
    tbl[5] = '{16'hFFFF, 5'd3,  16'h0002, 5'd7,  5'h00, 1'b0, 1'b1, 1'b0, {16'h0001, 5'd7, 5'd3}};
    tbl[6] = '{16'hFFFF, 5'd3,  16'h0002, 5'd7,  5'h00, 1'b0, 1'b0, 1'b1, {16'hFFFE, 5'd7, 5'd3}};
    tbl[7] = '{16'hFFFF, 5'd31, 16'h1234, 5'd31, 5'h1F, 1'b1, 1'b1, 1'b0, {16'h001E, 5'd0, 5'd31}};
    tbl[8] = '{16'hFFFF, 5'd31, 16'h1234, 5'd31, 5'h1F, 1'b1, 1'b1, 1'b1, {SGN ? 16'hFFFF : 16'h001E, 5'd0, 5'd31}};
    tbl[9] = '{16'hFFFF, 5'd31, 16'hFFFF, 5'd31, 5'h00, 1'b0, 1'b0, 1'b0, {16'h0001, 5'd31, 5'd31}};

    rst_n = 1'b0; in_valid = 1'b0; in_r0 = '0; in_r1 = '0; in_imm = '0;
    in_imm_sel = 1'b0; in_high = 1'b0; in_signed = 1'b0; flush = 1'b0; out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_res", out_res, 0);
    rst_n = 1'b1;
    #1;
    check("rel_in_ready", in_ready, 1);

    for (int i = 0; i < 10; i++) issue_and_check($sformatf("vec%0d", i), tbl[i]);

    // Back-to-back low then high half must emerge on consecutive cycles
    @(negedge clk);
    drive(tbl[2]); in_valid = 1'b1;
    @(negedge clk);
    drive(tbl[3]);
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c < 20 && !out_valid; c++) @(negedge clk);
    check("b2b_first", {out_valid, out_res}, {1'b1, tbl[2].exp});
    @(negedge clk);
    check("b2b_second", {out_valid, out_res}, {1'b1, tbl[3].exp});

    // Backpressure: only STAGES ops fit, output holds, then all drain in order
    for (int k = 0; k < 5; k++) begin
      bp[k] = '{16'(k + 3), 5'(k), 16'(16'h0100 + k), 5'(k + 10), 5'h00, 1'b0, 1'(k & 1), 1'b0, 26'h0};
      bp[k].exp = model(bp[k].r0, bp[k].t0, bp[k].r1, bp[k].t1, bp[k].imm, bp[k].isel, bp[k].high, bp[k].sgn);
    end
    @(negedge clk);
    sent = 0; got = 0; have = 1'b0; held = '0;
    out_ready = 1'b0;
    for (int c = 0; c < 40 && got < 5; c++) begin
      if (c > 0) @(negedge clk);
      out_ready = (c >= 8);
      if (sent < 5) begin drive(bp[sent]); in_valid = 1'b1; end
      else in_valid = 1'b0;
      #1;
      if (c == 7) begin
        check("bp_in_ready_low", in_ready, 0);
        check("bp_accepted", sent, 3);
        check("bp_first_held", held, bp[0].exp);
      end
      if (c < 8 && out_valid) begin
        if (!have) begin held = out_res; have = 1'b1; end
        else check("bp_hold", out_res, held);
      end
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        check($sformatf("bp_order%0d", got), out_res, bp[got].exp);
        got++;
      end
    end
    check("bp_count", got, 5);
    in_valid = 1'b0;

    // Flush kills two in-flight ops
    @(negedge clk);
    out_ready = 1'b1;
    drive(tbl[0]); in_valid = 1'b1;
    @(negedge clk);
    drive(tbl[2]);
    @(negedge clk);
    drive(tbl[3]); flush = 1'b1;
    #1;
    check("flush_in_ready", in_ready, 0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    check("flush_busy", busy, 0);
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (out_valid) seen = 1'b1;
      @(negedge clk);
    end
    check("flush_no_out", seen, 0);
    issue_and_check("post_flush", tbl[1]);

    // Reset mid-operation discards the op
    @(negedge clk);
    drive(tbl[3]); in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_state", {busy, out_valid, in_ready, out_res}, 29'h0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("mid_rst_no_out", seen, 0);

    // Randomized traffic against the scoreboard
    stall_prev = 1'b0; prev_res = '0;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      if (stall_prev) check("rnd_hold", {out_valid, out_res}, {1'b1, prev_res});
      rv = '{16'($urandom), 5'($urandom), 16'($urandom), 5'($urandom), 5'($urandom),
             1'($urandom), 1'($urandom), 1'($urandom), 26'h0};
      drive(rv);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      #1;
      if (out_valid && out_ready) begin
        if (q.size() == 0) check("rnd_spurious", 1, 0);
        else check("rnd_res", out_res, q.pop_front());
      end
      if (flush) q.delete();
      else if (in_valid && in_ready)
        q.push_back(model(rv.r0, rv.t0, rv.r1, rv.t1, rv.imm, rv.isel, rv.high, rv.sgn));
      stall_prev = out_valid && !out_ready && !flush;
      prev_res   = out_res;
    end
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (out_valid) begin
        if (q.size() == 0) check("drain_spurious", 1, 0);
        else check("drain_res", out_res, q.pop_front());
      end
      @(negedge clk);
    end
    check("drain_empty", q.size(), 0);
    check("drain_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
